// File: rtl/eq_fir_mac_engine.sv
// Time-multiplexed FIR stage: one tap per cycle against a combinational coefficient RAM,
// keeps the sample history, and emits one saturated Q-format sample per accepted input.
module eq_fir_mac_engine #(
  parameter int ADDR_WIDTH   = 4,
  parameter int COEF_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAC_BITS    = 15
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] in_data,
  input  logic                    flush,
  output logic [ADDR_WIDTH-1:0]   coef_addr,
  input  logic [COEF_WIDTH-1:0]   coef_data,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_WIDTH-1:0] out_data
);
  localparam int NTAPS  = 1 << ADDR_WIDTH;
  localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = SAMPLE_WIDTH + COEF_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TAP_LAST = ADDR_WIDTH'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e                               state_q, state_d;
  logic [NTAPS-1:0][SAMPLE_WIDTH-1:0]   hist_q, hist_d;
  logic signed [ACC_W-1:0]              acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]                tap_q, tap_d;
  logic                                 out_valid_q, out_valid_d;
  logic [SAMPLE_WIDTH-1:0]              out_data_q, out_data_d;

  logic signed [PROD_W-1:0]             prod;
  logic signed [ACC_W-1:0]              acc_sum;
  logic signed [ACC_W-1:0]              acc_shr;
  logic [SAMPLE_WIDTH-1:0]              sat_val;

  // Full-precision product and running sum; accumulator is wide enough to never wrap.
  always_comb begin
    prod    = $signed(hist_q[tap_q]) * $signed(coef_data);
    acc_sum = acc_q + ACC_W'(prod);
    acc_shr = acc_sum >>> FRAC_BITS;
    if (acc_shr > SAT_MAX)      sat_val = SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (acc_shr < SAT_MIN) sat_val = SAT_MIN[SAMPLE_WIDTH-1:0];
    else                        sat_val = acc_shr[SAMPLE_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      hist_q      <= '0;
      acc_q       <= '0;
      tap_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!flush && in_valid) state_d = S_MAC;
      S_MAC:   if (tap_q == TAP_LAST) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hist_d      = hist_q;
    acc_d       = acc_q;
    tap_d       = tap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        // Flush wins over a simultaneous sample so the cleared history is never polluted.
        if (flush) begin
          hist_d = '0;
        end else if (in_valid) begin
          hist_d = {hist_q[NTAPS-2:0], in_data};
          acc_d  = '0;
          tap_d  = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + 1'b1;
        if (tap_q == TAP_LAST) begin
          out_valid_d = 1'b1;
          out_data_d  = sat_val;
        end
      end
      S_OUT: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = resetn && (state_q == S_IDLE) && !flush;
    busy      = (state_q == S_MAC);
    coef_addr = busy ? tap_q : '0;
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

endmodule

// File: tb/tb_eq_fir_mac_engine.sv
// Bench for eq_fir_mac_engine: coefficient RAM modelled as an array, outputs checked
// against a convolution-sum reference with floor shift and clamp.
module tb_eq_fir_mac_engine;
  localparam int AW = 4;
  localparam int NTAPS = 1 << AW;

  logic               clk = 1'b0;
  logic               resetn, in_valid, flush, out_ready;
  logic               in_ready, busy, out_valid;
  logic signed [15:0] in_data, out_data;
  logic [AW-1:0]      coef_addr;
  logic [31:0]        coef_data;

  logic signed [31:0] coef [NTAPS];
  longint             hist_m [NTAPS];
  int                 total = 0;
  int                 bad = 0;

  always #5 clk = ~clk;
  assign coef_data = coef[coef_addr];

  eq_fir_mac_engine #(.ADDR_WIDTH(AW), .COEF_WIDTH(32), .SAMPLE_WIDTH(16), .FRAC_BITS(15)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NTAPS; k++) hist_m[k] = 0;
  endtask

  task automatic model_push(input int s);
    for (int k = NTAPS-1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = longint'(s);
  endtask

  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < NTAPS; k++) s += hist_m[k] * longint'(coef[k]);
    s = s >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic set_coefs(input int c0, input int step, input int rest);
    for (int k = 0; k < NTAPS; k++) coef[k] = (k == 0) ? c0 : rest + k * step;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    model_clear();
  endtask

  // One sample through the engine; optional latency/sweep checks and backpressure hold.
  task automatic send(input int s, input int hold, input bit tmg, input bit hasc, input int cwant);
    int n, nb;
    longint exp;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 16'(s);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = '0;
    model_push(s);
    exp = model_out();
    n = 0; nb = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk); n++;
      if (busy) begin
        if (tmg) chk("coef_addr", coef_addr, nb);
        nb++;
      end
    end
    if (tmg) begin
      chk("latency", n, NTAPS + 1);
      chk("busy_cycles", nb, NTAPS);
    end
    chk("out_valid", out_valid, 1);
    chk("out_model", out_data, exp);
    if (hasc) chk("out_const", out_data, cwant);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, exp);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    set_coefs(0, 0, 0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_coef_addr", coef_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk) resetn = 1'b1;

    // Identity, with latency/sweep on the first and backpressure on the second
    set_coefs(32768, 0, 0);
    send(1234, 0, 1'b1, 1'b1, 1234);
    send(-500, 5, 1'b0, 1'b1, -500);

    // Impulse response with ramp coefficients
    do_flush();
    set_coefs(0, 32768, 0);
    send(100, 0, 1'b1, 1'b1, 0);
    for (int i = 1; i < NTAPS; i++) send(0, 0, 1'b1, 1'b1, i * 100);

    // Saturation at both rails, then floor of a negative half
    do_flush();
    set_coefs(32768, 0, 32768);
    for (int i = 0; i < NTAPS; i++) send(32767, 0, 1'b0, 1'b1, 32767);
    for (int i = 0; i < NTAPS; i++) send(-32768, 0, 1'b0, i == NTAPS-1, -32768);
    do_flush();
    set_coefs(16384, 0, 0);
    send(-1, 0, 1'b0, 1'b1, -1);

    // Reset in the middle of the MAC sweep
    set_coefs(0, 32768, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd555;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_tap", coef_addr, 7);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_coef_addr", coef_addr, 0);
    @(negedge clk) resetn = 1'b1;
    model_clear();
    send(100, 0, 1'b0, 1'b1, 0);
    send(0, 0, 1'b0, 1'b1, 100);
    send(0, 0, 1'b0, 1'b1, 200);

    // Flush beats a simultaneous valid sample
    set_coefs(32768, 0, 32768);
    for (int i = 0; i < NTAPS; i++) send(1000, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'sd1000;
    #1 chk("flush_blocks_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("flush_no_busy", busy, 0);
    @(negedge clk);
    chk("flush_still_idle", busy, 0);
    chk("flush_no_out", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    model_clear();
    send(7, 0, 1'b0, 1'b1, 7);

    // Random samples against the reference, small then full-range coefficients
    do_flush();
    for (int k = 0; k < NTAPS; k++) coef[k] = int'($urandom_range(0, 131071)) - 65536;
    for (int i = 0; i < 24; i++) send(int'($urandom_range(0, 65535)) - 32768, 0, 1'b0, 1'b0, 0);
    for (int k = 0; k < NTAPS; k++) coef[k] = $urandom;
    for (int i = 0; i < 12; i++) send(int'($urandom_range(0, 65535)) - 32768, i % 4, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
